alu_interface_module: RTL and testbench
=======================================

# alu_interface_module

Sequencing front-end for the ALU in the UART loopback design. Collects three bytes from the UART receiver (operand A, operand B, opcode), drives them into the ALU, captures the combinational result and hands it to the UART transmitter as a single byte. Sits between `uart_rx`/`uart_tx` and `alu_module` in the top level; it is the producer of the ALU's inputs and the consumer of its output.

## Interface
Parameters:
- `NB_DATA`, 8: data byte width; equals ALU data width and UART word width.
- `NB_OP`, 6: ALU opcode width.

Ports:
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  NB_DATA  received byte from UART RX.
- `i_rx_done`  in  1  one-cycle pulse; `i_rx_data` valid this cycle.
- `i_alu_RES`  in  NB_DATA  ALU result (combinational from `o_alu_A/B/OP`).
- `i_tx_done`  in  1  one-cycle pulse from UART TX when the stop bit finishes.
- `o_alu_A`  out  NB_DATA  registered operand A to ALU.
- `o_alu_B`  out  NB_DATA  registered operand B to ALU.
- `o_alu_OP`  out  NB_OP  registered opcode to ALU.
- `o_tx_data`  out  NB_DATA  byte for UART TX, held stable until `i_tx_done`.
- `o_tx_start`  out  1  one-cycle pulse requesting TX of `o_tx_data`.
- `o_busy`  out  1  high from SEND entry until `i_tx_done`; RX bytes dropped while high.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on `i_rx_done`, `o_alu_A <= i_rx_data`, go WAIT_B.
- WAIT_B: on `i_rx_done`, `o_alu_B <= i_rx_data`, go WAIT_OP.
- WAIT_OP: on `i_rx_done`, `o_alu_OP <= i_rx_data[NB_OP-1:0]` (upper bits discarded), go SEND.
- SEND (exactly one cycle): `o_tx_data <= i_alu_RES`, `o_tx_start <= 1`, go WAIT_TX.
- WAIT_TX: `o_tx_start` back to 0; on `i_tx_done` go WAIT_A. Operand/opcode registers keep their values until overwritten.
- `i_rx_done` in SEND or WAIT_TX: byte ignored, no state change, no register update.
- `i_tx_done` outside WAIT_TX: ignored.
- Invalid opcodes are not filtered; whatever ALU returns (0x00 for undefined ops) is transmitted.
- No width arithmetic inside the block; result byte passed through unchanged.

## Timing
- Reset values: `o_alu_A`, `o_alu_B`, `o_tx_data` = 0; `o_alu_OP` = 0; `o_tx_start` = 0; `o_busy` = 0; state WAIT_A.
- Reset asserted in any state (including mid-sequence or WAIT_TX) returns to WAIT_A next edge; partially collected operands discarded; a pending TX is abandoned (a later `i_tx_done` is ignored).
- Opcode byte `i_rx_done` at edge N: `o_alu_OP` valid and state SEND after N; `o_tx_start` high and `o_tx_data` valid for the single cycle after N+1; `o_busy` high from after N until the edge sampling `i_tx_done`.
- Latency OP-byte pulse to `o_tx_start`: 2 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared header `alu_defs.vh`: ALU opcode localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111) and FSM state encodings; used by this block, the ALU and the bench.
- Single module, no sub-modules; top level wires `uart_rx` -> `alu_interface_module` <-> `alu_module`, and `alu_interface_module` -> `uart_tx`.

## Test plan
Bench instantiates this block plus `alu_module`; RX/TX modelled by pulse drivers.
- Bytes 0x05, 0x03, 0x20 -> `o_tx_start` pulse 2 cycles after third `i_rx_done`, `o_tx_data`=0x08, `o_busy` high until `i_tx_done`.
- Bytes 0x03, 0x05, 0x22 (SUB) -> `o_tx_data`=0xFE; then 0xF0, 0x02, 0x03 (SRA) -> 0xFC.
- Opcode byte 0xE0 -> `o_alu_OP`=6'h20, ADD performed; opcode 0x3F -> `o_tx_data`=0x00.
- Extra byte 0x77 pulsed during WAIT_TX -> dropped; after `i_tx_done`, next three bytes form a fresh operation with A unaffected by 0x77.
- `i_reset` one cycle after A=0x11 received -> all outputs 0, state WAIT_A; next bytes 0x01, 0x01, 0x20 yield 0x02.
- `i_tx_done` pulsed in WAIT_A/WAIT_B -> no effect; `i_reset` during WAIT_TX then late `i_tx_done` -> no `o_tx_start`, state stays WAIT_A.

Source files
------------

// File: rtl/alu_interface_module_pkg.sv
// Shared definitions for the ALU sequencing front-end: ALU opcode values
// and the encoding of the byte-collection / transmit state machine.
package alu_interface_module_pkg;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4
   } state_e;

endpackage

// File: rtl/alu_interface_module.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// presents them to the ALU, then hands the ALU result to the UART transmitter.
module alu_interface_module
   import alu_interface_module_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_alu_RES,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_alu_A,
   output logic [NB_DATA-1:0] o_alu_B,
   output logic [NB_OP-1:0]   o_alu_OP,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy
);

   state_e               state_q;
   logic [NB_DATA-1:0]   alu_a_q;
   logic [NB_DATA-1:0]   alu_b_q;
   logic [NB_OP-1:0]     alu_op_q;
   logic [NB_DATA-1:0]   tx_data_q;
   logic                 tx_start_q;
   logic                 busy_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_WAIT_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            ST_WAIT_A: begin
               if (i_rx_done) begin
                  alu_a_q <= i_rx_data;
                  state_q <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (i_rx_done) begin
                  alu_b_q <= i_rx_data;
                  state_q <= ST_WAIT_OP;
               end
            end
            ST_WAIT_OP: begin
               // Upper opcode bits are dropped; invalid opcodes pass to the ALU.
               if (i_rx_done) begin
                  alu_op_q <= i_rx_data[NB_OP-1:0];
                  busy_q   <= 1'b1;
                  state_q  <= ST_SEND;
               end
            end
            ST_SEND: begin
               // ALU inputs settled during the previous cycle, so its result is stable here.
               tx_data_q  <= i_alu_RES;
               tx_start_q <= 1'b1;
               state_q    <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (i_tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_A;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_WAIT_A;
            end
         endcase
      end
   end

   assign o_alu_A    = alu_a_q;
   assign o_alu_B    = alu_b_q;
   assign o_alu_OP   = alu_op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_interface_module.sv
// Randomized self-checking bench for alu_interface_module; the ALU and UART
// ends are modelled behaviourally inside the bench.
module tb_alu_interface_module;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] alu_res;
   logic       tx_done;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Behavioural ALU: plain arithmetic on the opcode, 0x00 for undefined codes.
   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h03:   return sa >>> b;
         6'h02:   return a >> b;
         6'h27:   return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu_res = alu_ref(alu_a, alu_b, alu_op);

   alu_interface_module #(.NB_DATA(8), .NB_OP(6)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_rx_data  (rx_data),
      .i_rx_done  (rx_done),
      .i_alu_RES  (alu_res),
      .i_tx_done  (tx_done),
      .o_alu_A    (alu_a),
      .o_alu_B    (alu_b),
      .o_alu_OP   (alu_op),
      .o_tx_data  (tx_data),
      .o_tx_start (tx_start),
      .o_busy     (busy)
   );

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   // Sends a full operation and follows it up to the WAIT_TX hold.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input string name);
      logic [7:0] exp;
      exp = alu_ref(a, b, opb[5:0]);
      send_byte(a);
      n_checks++;
      if (alu_a !== a) $display("FAIL %s_A: got %h want %h", name, alu_a, a);
      else n_pass++;
      send_byte(b);
      n_checks++;
      if (alu_b !== b) $display("FAIL %s_B: got %h want %h", name, alu_b, b);
      else n_pass++;
      send_byte(opb);
      n_checks++;
      if (alu_op !== opb[5:0]) $display("FAIL %s_OP: got %h want %h", name, alu_op, opb[5:0]);
      else n_pass++;
      n_checks++;
      if (tx_start !== 1'b0 || busy !== 1'b1)
         $display("FAIL %s_send_entry: start=%b busy=%b want start=0 busy=1", name, tx_start, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b1 || tx_data !== exp)
         $display("FAIL %s_start: start=%b data=%h want start=1 data=%h", name, tx_start, tx_data, exp);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0 || tx_data !== exp || busy !== 1'b1)
         $display("FAIL %s_hold: start=%b data=%h busy=%b want 0/%h/1", name, tx_start, tx_data, busy, exp);
      else n_pass++;
   endtask

   task automatic finish_tx(input string name);
      pulse_tx_done();
      n_checks++;
      if (busy !== 1'b0 || tx_start !== 1'b0)
         $display("FAIL %s_txdone: busy=%b start=%b want 0/0", name, busy, tx_start);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 32'h0)
         $display("FAIL reset_outputs: A=%h B=%h OP=%h D=%h S=%b busy=%b want all 0",
                  alu_a, alu_b, alu_op, tx_data, tx_start, busy);
      else n_pass++;
   endtask

   task automatic test_directed();
      start_op(8'h05, 8'h03, 8'h20, "add");
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b1) $display("FAIL add_busy_hold: got %b want 1", busy);
         else n_pass++;
      end
      finish_tx("add");
      start_op(8'h03, 8'h05, 8'h22, "sub");
      finish_tx("sub");
      start_op(8'hF0, 8'h02, 8'h03, "sra");
      finish_tx("sra");
      start_op(8'h10, 8'h07, 8'hE0, "add_hi_bits");
      finish_tx("add_hi_bits");
      start_op(8'h12, 8'h34, 8'h3F, "undef_op");
      n_checks++;
      if (tx_data !== 8'h00) $display("FAIL undef_op_zero: got %h want 00", tx_data);
      else n_pass++;
      finish_tx("undef_op");
   endtask

   task automatic test_drop_in_wait_tx();
      start_op(8'h21, 8'h04, 8'h24, "drop");
      send_byte(8'h77);
      n_checks++;
      if (alu_a !== 8'h21 || alu_b !== 8'h04 || alu_op !== 6'h24 || tx_start !== 1'b0)
         $display("FAIL drop_regs: A=%h B=%h OP=%h S=%b want 21/04/24/0", alu_a, alu_b, alu_op, tx_start);
      else n_pass++;
      finish_tx("drop");
      start_op(8'h09, 8'h01, 8'h20, "after_drop");
      finish_tx("after_drop");
   endtask

   task automatic test_reset_mid_sequence();
      send_byte(8'h11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 32'h0)
         $display("FAIL midreset_outputs: A=%h B=%h OP=%h D=%h S=%b busy=%b want all 0",
                  alu_a, alu_b, alu_op, tx_data, tx_start, busy);
      else n_pass++;
      start_op(8'h01, 8'h01, 8'h20, "post_reset");
      finish_tx("post_reset");
   endtask

   task automatic test_stray_tx_done();
      int starts;
      pulse_tx_done();
      send_byte(8'h0C);
      pulse_tx_done();
      n_checks++;
      if (alu_a !== 8'h0C || busy !== 1'b0) $display("FAIL stray_done_A: A=%h busy=%b want 0c/0", alu_a, busy);
      else n_pass++;
      send_byte(8'h0A);
      send_byte(8'h26);
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'h06)
         $display("FAIL stray_done_result: start=%b data=%h want 1/06", tx_start, tx_data);
      else n_pass++;
      // Abandon the pending transmit with a reset, then a late tx_done must do nothing.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      starts = 0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (5) begin
         if (tx_start === 1'b1 || busy === 1'b1) starts++;
         @(negedge clk);
      end
      n_checks++;
      if (starts != 0) $display("FAIL late_done_ignored: %0d active cycles, want 0", starts);
      else n_pass++;
      start_op(8'h40, 8'h01, 8'h02, "after_late_done");
      finish_tx("after_late_done");
   endtask

   task automatic test_random();
      logic [7:0] ops [0:7];
      logic [7:0] a, b, opb, junk;
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) opb = 8'($urandom);
         else opb = ops[$urandom_range(0, 7)] | {2'($urandom), 6'h00};
         start_op(a, b, opb, "rand");
         if ($urandom_range(0, 1) == 1) begin
            junk = 8'($urandom);
            send_byte(junk);
            n_checks++;
            if (alu_a !== a || alu_b !== b || alu_op !== opb[5:0])
               $display("FAIL rand_drop: A=%h B=%h OP=%h want %h/%h/%h", alu_a, alu_b, alu_op, a, b, opb[5:0]);
            else n_pass++;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         finish_tx("rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_drop_in_wait_tx();
      test_reset_mid_sequence();
      test_stray_tx_done();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
